// File: rtl/audio_sd_dac.sv
// First-order sigma-delta audio DAC with click-free ramp to/from silence.
// Ports: clk, reset (async high), audio_en strobe, signed sample, mute level; dac_out bitstream, running/muted status.
module audio_sd_dac #(
  parameter int WIDTH      = 8,
  parameter int RAMP_SHIFT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             audio_en,
  input  logic [WIDTH-1:0] sample,
  input  logic             mute,
  output logic             dac_out,
  output logic             running,
  output logic             muted
);

  typedef enum logic [1:0] {
    S_RAMP_UP,
    S_RUN,
    S_RAMP_DOWN,
    S_MUTED
  } state_t;

  // Counter keeps at least one bit so RAMP_SHIFT=0 stays legal;
  // the mask then makes every strobe a tick.
  localparam int CW = (RAMP_SHIFT > 0) ? RAMP_SHIFT : 1;
  localparam logic [CW-1:0] CMASK = CW'((1 << RAMP_SHIFT) - 1);
  localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state, state_n;
  logic [WIDTH-1:0] bias, bias_n;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] level;
  logic [WIDTH:0]   sum;
  logic [CW-1:0]    cnt, cnt_inc;
  logic             tick;

  assign cnt_inc = (cnt + 1'b1) & CMASK;
  assign tick    = audio_en && (cnt_inc == '0);

  always_comb begin
    state_n = state;
    bias_n  = bias;
    unique case (state)
      S_RAMP_UP: begin
        if (mute) begin
          state_n = S_RAMP_DOWN;
        end else if (bias == HALF) begin
          state_n = S_RUN;
        end else if (tick) begin
          bias_n = bias + 1'b1;
          if (bias_n == HALF) state_n = S_RUN;
        end
      end
      S_RUN: begin
        if (mute) begin
          state_n = S_RAMP_DOWN;
          bias_n  = HALF;
        end
      end
      S_RAMP_DOWN: begin
        if (!mute) begin
          state_n = S_RAMP_UP;
        end else if (bias == '0) begin
          state_n = S_MUTED;
        end else if (tick) begin
          bias_n = bias - 1'b1;
          if (bias_n == '0) state_n = S_MUTED;
        end
      end
      S_MUTED: begin
        if (!mute) begin
          state_n = S_RAMP_UP;
          bias_n  = '0;
        end
      end
      default: begin
        state_n = S_RAMP_UP;
        bias_n  = '0;
      end
    endcase
  end

  // Offset binary in RUN so a signed zero sits at half scale.
  always_comb begin
    level = '0;
    unique case (state)
      S_RUN:       level = {~hold[WIDTH-1], hold[WIDTH-2:0]};
      S_RAMP_UP,
      S_RAMP_DOWN: level = bias;
      default:     level = '0;
    endcase
  end

  assign sum = {1'b0, acc} + {1'b0, level};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_RAMP_UP;
      bias    <= '0;
      hold    <= '0;
      acc     <= '0;
      cnt     <= '0;
      dac_out <= 1'b0;
      running <= 1'b0;
      muted   <= 1'b0;
    end else begin
      state   <= state_n;
      bias    <= bias_n;
      acc     <= sum[WIDTH-1:0];
      dac_out <= sum[WIDTH];
      running <= (state_n == S_RUN);
      muted   <= (state_n == S_MUTED);
      if (audio_en) hold <= sample;
      if (state_n != state) cnt <= '0;
      else if (audio_en) cnt <= cnt_inc;
    end
  end

endmodule

// File: tb/tb_audio_sd_dac.sv
// Directed bench for audio_sd_dac (WIDTH=8, RAMP_SHIFT=0).
// Drives and samples on the falling edge; each negedge follows one rising edge.
module tb_audio_sd_dac;

  logic       clk = 1'b0;
  logic       reset;
  logic       audio_en;
  logic [7:0] sample;
  logic       mute;
  logic       dac_out;
  logic       running;
  logic       muted;

  int n_chk  = 0;
  int n_pass = 0;

  audio_sd_dac #(.WIDTH(8), .RAMP_SHIFT(0)) dut (
    .clk      (clk),
    .reset    (reset),
    .audio_en (audio_en),
    .sample   (sample),
    .mute     (mute),
    .dac_out  (dac_out),
    .running  (running),
    .muted    (muted)
  );

  always #5 clk = ~clk;

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; audio_en = 1'b1; sample = 8'h00; mute = 1'b0;
    edges(3);
    n_chk++;
    if (dac_out !== 1'b0) $display("FAIL rst_dac got %b want 0", dac_out);
    else n_pass++;
    n_chk++;
    if (running !== 1'b0) $display("FAIL rst_running got %b want 0", running);
    else n_pass++;
    n_chk++;
    if (muted !== 1'b0) $display("FAIL rst_muted got %b want 0", muted);
    else n_pass++;
  endtask

  // Released at a negedge: 128 ticks take 128 rising edges.
  task automatic test_ramp_up(input string tag);
    reset = 1'b0;
    edges(127);
    n_chk++;
    if (running !== 1'b0) $display("FAIL %s_early got %b want 0", tag, running);
    else n_pass++;
    edges(1);
    n_chk++;
    if (running !== 1'b1) $display("FAIL %s_run got %b want 1", tag, running);
    else n_pass++;
    n_chk++;
    if (muted !== 1'b0) $display("FAIL %s_muted got %b want 0", tag, muted);
    else n_pass++;
  endtask

  task automatic test_density(input logic [7:0] s, input int want);
    int ones;
    sample = s;
    edges(4);
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      edges(1);
      if (dac_out === 1'b1) ones++;
    end
    n_chk++;
    if (ones !== want)
      $display("FAIL density_%h got %0d want %0d", s, ones, want);
    else n_pass++;
  endtask

  // From level 0 the accumulator is frozen; full scale must not show at
  // the first edge but must show within the next two.
  task automatic test_latency;
    logic b1, b2, b3;
    sample = 8'h80;
    edges(4);
    sample = 8'h7F;
    edges(1); b1 = dac_out;
    edges(1); b2 = dac_out;
    edges(1); b3 = dac_out;
    n_chk++;
    if (b1 !== 1'b0) $display("FAIL latency_edge1 got %b want 0", b1);
    else n_pass++;
    n_chk++;
    if ((b2 | b3) !== 1'b1)
      $display("FAIL latency_edge23 got %b%b want a 1", b2, b3);
    else n_pass++;
  endtask

  task automatic test_mute_down;
    int ones;
    sample = 8'h7F;
    mute = 1'b1;
    edges(1);
    n_chk++;
    if (running !== 1'b0) $display("FAIL mute_running got %b want 0", running);
    else n_pass++;
    edges(127);
    n_chk++;
    if (muted !== 1'b0) $display("FAIL mute_early got %b want 0", muted);
    else n_pass++;
    edges(1);
    n_chk++;
    if (muted !== 1'b1) $display("FAIL mute_done got %b want 1", muted);
    else n_pass++;
    ones = 0;
    for (int i = 0; i < 300; i++) begin
      edges(1);
      if (dac_out !== 1'b0) ones++;
    end
    n_chk++;
    if (ones !== 0) $display("FAIL mute_silent got %0d ones want 0", ones);
    else n_pass++;
  endtask

  task automatic test_unmute_from_muted;
    mute = 1'b0;
    edges(128);
    n_chk++;
    if (running !== 1'b0) $display("FAIL unmute_early got %b want 0", running);
    else n_pass++;
    edges(1);
    n_chk++;
    if (running !== 1'b1) $display("FAIL unmute_run got %b want 1", running);
    else n_pass++;
  endtask

  // One edge to enter RAMP_DOWN at 128, 68 ticks to reach 60.
  task automatic test_abort_down;
    mute = 1'b1;
    edges(69);
    n_chk++;
    if (running !== 1'b0 || muted !== 1'b0)
      $display("FAIL abort_state got r%b m%b want r0 m0", running, muted);
    else n_pass++;
    mute = 1'b0;
    edges(68);
    n_chk++;
    if (running !== 1'b0) $display("FAIL abort_early got %b want 0", running);
    else n_pass++;
    edges(1);
    n_chk++;
    if (running !== 1'b1) $display("FAIL abort_run got %b want 1", running);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run;
    int guard;
    sample = 8'h7F;
    edges(4);
    guard = 0;
    while (dac_out !== 1'b1 && guard < 16) begin
      edges(1);
      guard++;
    end
    n_chk++;
    if (dac_out !== 1'b1) $display("FAIL midrst_pre got %b want 1", dac_out);
    else n_pass++;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_chk++;
    if (dac_out !== 1'b0) $display("FAIL midrst_dac got %b want 0", dac_out);
    else n_pass++;
    n_chk++;
    if (running !== 1'b0) $display("FAIL midrst_run got %b want 0", running);
    else n_pass++;
    edges(2);
    test_ramp_up("midrst_ramp");
  endtask

  initial begin
    test_reset();
    test_ramp_up("ramp");
    test_density(8'h00, 128);
    test_density(8'h7F, 255);
    test_density(8'h80, 0);
    test_density(8'h40, 192);
    test_density(8'hC0, 64);
    test_latency();
    test_mute_down();
    test_unmute_from_muted();
    test_abort_down();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/audio_sd_dac.md
AUDIO_SD_DAC -- requirements
Module: audio_sd_dac

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the sample width in bits.
REQ-002 SHALL have parameter RAMP_SHIFT, default 4; one ramp tick occurs every 2^RAMP_SHIFT audio_en strobes.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port audio_en, input, 1 bit: sample strobe, one clk wide.
REQ-006 SHALL have port sample, input, WIDTH bits: signed two's-complement audio sample.
REQ-007 SHALL have port mute, input, 1 bit: a level, 1 requests ramp to silence.
REQ-008 SHALL have port dac_out, output, 1 bit: registered 1st-order sigma-delta bitstream.
REQ-009 SHALL have port running, output, 1 bit: high only in state RUN.
REQ-010 SHALL have port muted, output, 1 bit: high only in state MUTED.

Function
REQ-011 SHALL latch sample into hold register on each clk where audio_en=1; hold unchanged otherwise.
REQ-012 SHALL form level[WIDTH-1:0]: in RUN = hold with MSB inverted (offset binary); in RAMP_UP/RAMP_DOWN = bias; in MUTED = 0.
REQ-013 SHALL update accumulator every clk: {carry,acc} = acc + level (WIDTH+1-bit sum); dac_out <= carry; acc <= low WIDTH bits.
REQ-014 SHALL give 2-clk latency from sample latch to first dac_out effect; long-run density of dac_out = level/2^WIDTH exactly, i.e. level ones per 2^WIDTH clks.
REQ-015 SHALL implement states RAMP_UP, RUN, RAMP_DOWN, MUTED; bias is unsigned WIDTH bits, range 0..2^(WIDTH-1).
REQ-016 SHALL count audio_en strobes in a RAMP_SHIFT-bit counter; a tick fires on the strobe where counter wraps to 0; counter clears on every state change.
REQ-017 RAMP_UP: each tick bias+1; when bias reaches 2^(WIDTH-1) -> RUN (mute=0) or RAMP_DOWN (mute=1).
REQ-018 RAMP_UP with mute=1 SHALL go to RAMP_DOWN next clk, keeping current bias.
REQ-019 RUN: mute=1 SHALL go to RAMP_DOWN next clk with bias=2^(WIDTH-1).
REQ-020 RAMP_DOWN: each tick bias-1; on reaching 0 -> MUTED; mute=0 SHALL go to RAMP_UP next clk keeping current bias.
REQ-021 MUTED: mute=0 SHALL go to RAMP_UP next clk with bias=0.
REQ-022 Bias SHALL never wrap: no increment at 2^(WIDTH-1), no decrement at 0.
REQ-023 Simultaneous tick and mute change: state transition wins; the tick is discarded.
REQ-024 running/muted SHALL be registered, decoded from state, valid same cycle as state.

Reset
REQ-025 reset=1 SHALL immediately force: state RAMP_UP, bias 0, hold 0, acc 0, strobe counter 0, dac_out 0, running 0, muted 0.
REQ-026 Reset asserted mid-operation SHALL abort any ramp; after release, operation restarts with a full RAMP_UP from bias 0.

Verification (WIDTH=8, RAMP_SHIFT=0, audio_en=1 every clk unless stated)
REQ-027 Release reset, mute=0 -> RAMP_UP; bias 0..128 over 128 ticks; running=1 immediately after the 128th tick.
REQ-028 RUN, sample=0x00 held -> exactly 128 ones in any 256 consecutive dac_out bits.
REQ-029 RUN, sample=0x7F -> 255 ones per 256 clks; sample=0x80 -> 0 ones per 256 clks.
REQ-030 RUN, mute=1 -> RAMP_DOWN; muted=1 after 128 ticks; dac_out stays 0 thereafter.
REQ-031 In RAMP_DOWN at bias=60, mute->0 -> RAMP_UP from 60; running=1 after 68 ticks.
REQ-032 Reset pulse mid-RUN, asynchronous to clk -> dac_out=0 and running=0 before the next clk edge; full 128-tick RAMP_UP after release.
